// File: rtl/svm_batch_builder.sv
// Batching stage between the insertion queue and execution dispatch: gathers mutually
// non-conflicting transactions into a batch, then drains it in order with tlast and a batch ID.
module svm_batch_builder #(
  parameter int MAX_DEPENDENCIES     = 256,
  parameter int MAX_BATCH_SIZE       = 8,
  parameter int BATCH_TIMEOUT_CYCLES = 100,
  parameter int BATCH_ID_W           = 16,
  parameter int CNT_W                = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [63:0]                 s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [63:0]                 m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  output logic [BATCH_ID_W-1:0]       m_axis_tdata_batch_id,
  output logic [CNT_W-1:0]            raw_conflicts,
  output logic [CNT_W-1:0]            waw_conflicts,
  output logic [CNT_W-1:0]            war_conflicts,
  output logic [CNT_W-1:0]            batches_closed,
  output logic [CNT_W-1:0]            timeout_closes
);

  localparam int CW = $clog2(MAX_BATCH_SIZE + 1);
  localparam int PW = (MAX_BATCH_SIZE > 1) ? $clog2(MAX_BATCH_SIZE) : 1;
  localparam int AW = $clog2(BATCH_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_BATCH_SIZE);
  localparam logic [AW-1:0] AGE_MAX   = AW'(BATCH_TIMEOUT_CYCLES);

  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_e;

  typedef struct packed {
    logic [63:0]                 owner;
    logic [MAX_DEPENDENCIES-1:0] rd;
    logic [MAX_DEPENDENCIES-1:0] wr;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  state_e                      state_q, state_d;
  logic [CW-1:0]               count_q, count_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]               age_q, age_d;
  logic [MAX_DEPENDENCIES-1:0] acc_rd_q, acc_rd_d;
  logic [MAX_DEPENDENCIES-1:0] acc_wr_q, acc_wr_d;
  logic [BATCH_ID_W-1:0]       batch_id_q, batch_id_d;
  logic [CNT_W-1:0]            raw_q, raw_d, waw_q, waw_d, war_q, war_d;
  logic [CNT_W-1:0]            closed_q, closed_d, tmo_q, tmo_d;
  entry_t                      entry_q [MAX_BATCH_SIZE];
  entry_t                      entry_d [MAX_BATCH_SIZE];

  logic          raw_s, waw_s, war_s, conf_s;
  logic          full_s, timeout_s, accept_s, last_s;
  logic [PW-1:0] wr_idx_s;

  assign raw_s     = |(s_axis_tdata_read_dependencies & acc_wr_q);
  assign waw_s     = |(s_axis_tdata_write_dependencies & acc_wr_q);
  assign war_s     = |(s_axis_tdata_write_dependencies & acc_rd_q);
  assign conf_s    = raw_s | waw_s | war_s;
  assign full_s    = (count_q == COUNT_MAX);
  assign timeout_s = (count_q != '0) && (age_q == AGE_MAX);
  assign last_s    = (CW'(rd_ptr_q) == (count_q - CW'(1)));
  assign wr_idx_s  = PW'(count_q);

  // tready looks at the data (conflict check) but never at tvalid
  assign s_axis_tready = rst_n && (state_q == ST_FILL) && !full_s && !conf_s && !timeout_s;
  assign accept_s      = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid                   = rst_n && (state_q == ST_DRAIN);
  assign m_axis_tlast                    = m_axis_tvalid && last_s;
  assign m_axis_tdata_owner_programID    = entry_q[rd_ptr_q].owner;
  assign m_axis_tdata_read_dependencies  = entry_q[rd_ptr_q].rd;
  assign m_axis_tdata_write_dependencies = entry_q[rd_ptr_q].wr;
  assign m_axis_tdata_batch_id           = batch_id_q;
  assign raw_conflicts                   = raw_q;
  assign waw_conflicts                   = waw_q;
  assign war_conflicts                   = war_q;
  assign batches_closed                  = closed_q;
  assign timeout_closes                  = tmo_q;

  // Next-state: fill/close decision in FILL, in-order drain in DRAIN
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    age_d      = age_q;
    acc_rd_d   = acc_rd_q;
    acc_wr_d   = acc_wr_q;
    batch_id_d = batch_id_q;
    raw_d      = raw_q;
    waw_d      = waw_q;
    war_d      = war_q;
    closed_d   = closed_q;
    tmo_d      = tmo_q;
    entry_d    = entry_q;
    case (state_q)
      ST_FILL: begin
        if (full_s) begin
          state_d = ST_DRAIN;
        end else if (timeout_s) begin
          state_d = ST_DRAIN;
          tmo_d   = sat_inc(tmo_q, 1'b1);
        end else if (s_axis_tvalid && conf_s) begin
          // Counted only here: the stalled transaction meets empty sets after the drain
          state_d = ST_DRAIN;
          raw_d   = sat_inc(raw_q, raw_s);
          waw_d   = sat_inc(waw_q, waw_s);
          war_d   = sat_inc(war_q, war_s);
        end else if (accept_s) begin
          entry_d[wr_idx_s] = {s_axis_tdata_owner_programID,
                               s_axis_tdata_read_dependencies,
                               s_axis_tdata_write_dependencies};
          count_d  = count_q + CW'(1);
          acc_rd_d = acc_rd_q | s_axis_tdata_read_dependencies;
          acc_wr_d = acc_wr_q | s_axis_tdata_write_dependencies;
          age_d    = (count_q == '0) ? AW'(1) : age_q + AW'(1);
        end else if (count_q != '0) begin
          age_d = age_q + AW'(1);
        end else begin
          age_d = '0;
        end
      end
      ST_DRAIN: begin
        if (m_axis_tready && last_s) begin
          state_d    = ST_FILL;
          count_d    = '0;
          rd_ptr_d   = '0;
          age_d      = '0;
          acc_rd_d   = '0;
          acc_wr_d   = '0;
          batch_id_d = batch_id_q + BATCH_ID_W'(1);
          closed_d   = sat_inc(closed_q, 1'b1);
        end else if (m_axis_tready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Control state and statistics with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      age_q      <= '0;
      acc_rd_q   <= '0;
      acc_wr_q   <= '0;
      batch_id_q <= '0;
      raw_q      <= '0;
      waw_q      <= '0;
      war_q      <= '0;
      closed_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      age_q      <= age_d;
      acc_rd_q   <= acc_rd_d;
      acc_wr_q   <= acc_wr_d;
      batch_id_q <= batch_id_d;
      raw_q      <= raw_d;
      waw_q      <= waw_d;
      war_q      <= war_d;
      closed_q   <= closed_d;
      tmo_q      <= tmo_d;
    end
  end

  // Batch storage; contents are only visible below count, so no reset needed
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_svm_batch_builder.sv
// Directed self-checking bench for svm_batch_builder with default parameters.
module tb_svm_batch_builder;
  localparam int DEP = 256;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [63:0]    s_owner = '0;
  logic [DEP-1:0] s_rd = '0;
  logic [DEP-1:0] s_wr = '0;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic           m_tlast;
  logic [63:0]    m_owner;
  logic [DEP-1:0] m_rd, m_wr;
  logic [15:0]    m_bid;
  logic [31:0]    raw_c, waw_c, war_c, closed_c, tmo_c;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0]    owner;
    logic [DEP-1:0] rd;
    logic [DEP-1:0] wr;
    logic           last;
    logic [15:0]    bid;
  } beat_t;
  beat_t mon_q[$];

  always #5 clk = ~clk;

  svm_batch_builder dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata_owner_programID(s_owner),
    .s_axis_tdata_read_dependencies(s_rd),
    .s_axis_tdata_write_dependencies(s_wr),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tdata_owner_programID(m_owner),
    .m_axis_tdata_read_dependencies(m_rd),
    .m_axis_tdata_write_dependencies(m_wr),
    .m_axis_tdata_batch_id(m_bid),
    .raw_conflicts(raw_c), .waw_conflicts(waw_c), .war_conflicts(war_c),
    .batches_closed(closed_c), .timeout_closes(tmo_c)
  );

  // Record every output handshake that the next rising edge will complete
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready)
      mon_q.push_back('{m_owner, m_rd, m_wr, m_tlast, m_bid});
  end

  task automatic chk(input string tag, input logic [DEP-1:0] got, input logic [DEP-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    rst_n = 1'b1;
    mon_q.delete();
  endtask

  task automatic send(input logic [63:0] own, input logic [DEP-1:0] rd, input logic [DEP-1:0] wr,
                      output int waited);
    s_owner = own;
    s_rd = rd;
    s_wr = wr;
    s_tvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!s_tready && waited < 400) begin
      waited++;
      @(negedge clk);
    end
    if (!s_tready) chk("send_bound", s_tready, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (mon_q.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("beat_count", mon_q.size(), n);
  endtask

  task automatic exp_beat(input int i, input logic [63:0] own, input logic last, input logic [15:0] bid);
    if (i < mon_q.size()) begin
      chk($sformatf("b%0d_owner", i), mon_q[i].owner, own);
      chk($sformatf("b%0d_last", i), mon_q[i].last, last);
      chk($sformatf("b%0d_bid", i), mon_q[i].bid, bid);
    end else begin
      chk($sformatf("b%0d_missing", i), mon_q.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k;
    logic [DEP-1:0] b255;
    b255 = '0;
    b255[255] = 1'b1;

    // T1: single transaction closes by timeout
    do_reset();
    chk("rst_raw", raw_c, 0);
    chk("rst_closed", closed_c, 0);
    chk("rst_tmo", tmo_c, 0);
    chk("rst_tlast", m_tlast, 0);
    send(64'h11, 1, 2, w);
    chk("t1_wait", w, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_tvalid && k < 300);
    chk("t1_latency", k, 101);
    wait_beats(1, 10);
    exp_beat(0, 64'h11, 1'b1, 16'd0);
    if (mon_q.size() > 0) begin
      chk("t1_rd", mon_q[0].rd, 1);
      chk("t1_wr", mon_q[0].wr, 2);
    end
    chk("t1_tmo", tmo_c, 1);
    chk("t1_closed", closed_c, 1);

    // T2: RAW conflict stalls the second transaction into the next batch
    do_reset();
    send(64'h21, 1, 2, w);
    send(64'h22, 2, 0, w);
    chk("t2_stall", w, 2);
    chk("t2_raw", raw_c, 1);
    chk("t2_waw", waw_c, 0);
    chk("t2_war", war_c, 0);
    wait_beats(2, 300);
    exp_beat(0, 64'h21, 1'b1, 16'd0);
    exp_beat(1, 64'h22, 1'b1, 16'd1);
    chk("t2_raw_end", raw_c, 1);
    chk("t2_tmo", tmo_c, 1);
    chk("t2_closed", closed_c, 2);

    // T3: eight back-to-back readers of bit 255 fill one batch
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(64'h300 + 64'(i), b255, 0, w);
      chk($sformatf("t3_nostall%0d", i), w, 0);
    end
    wait_beats(8, 50);
    for (int i = 0; i < 8; i++) exp_beat(i, 64'h300 + 64'(i), (i == 7), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_closed", closed_c, 1);
    chk("t3_tmo", tmo_c, 0);
    chk("t3_raw", raw_c, 0);

    // T4: all three conflict kinds, counted once over a long stall
    do_reset();
    send(64'h41, 1, 2, w);
    m_tready = 1'b0;
    fork
      send(64'h47, 2, 3, w);
      begin
        repeat (6) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    chk("t4_stall", w, 7);
    chk("t4_raw", raw_c, 1);
    chk("t4_waw", waw_c, 1);
    chk("t4_war", war_c, 1);
    wait_beats(2, 300);
    exp_beat(1, 64'h47, 1'b1, 16'd1);
    chk("t4_raw_end", raw_c, 1);
    chk("t4_waw_end", waw_c, 1);
    chk("t4_war_end", war_c, 1);

    // T5: backpressure for ten cycles in the middle of a full batch
    do_reset();
    for (int i = 0; i < 8; i++) send(64'h500 + 64'(i), DEP'(1) << i, 0, w);
    k = 0;
    while (mon_q.size() < 3 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_hold_owner", m_owner, 64'h503);
      chk("t5_hold_rd", m_rd, DEP'(1) << 3);
      chk("t5_hold_last", m_tlast, 0);
      chk("t5_hold_valid", m_tvalid, 1);
      chk("t5_hold_sready", s_tready, 0);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    wait_beats(8, 50);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_dup", mon_q.size(), 8);
    for (int i = 0; i < 8; i++) exp_beat(i, 64'h500 + 64'(i), (i == 7), 16'd0);
    chk("t5_closed", closed_c, 1);

    // T6: one-cycle reset with three entries buffered
    mon_q.delete();
    for (int i = 0; i < 3; i++) send(64'h600 + 64'(i), DEP'(1) << (i + 8), 0, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_closed", closed_c, 0);
    chk("t6_tmo", tmo_c, 0);
    repeat (150) @(posedge clk);
    #1;
    chk("t6_no_output", mon_q.size(), 0);
    chk("t6_m_tvalid", m_tvalid, 0);
    send(64'h6A, 1, 0, w);
    wait_beats(1, 300);
    exp_beat(0, 64'h6A, 1'b1, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
